// File: rtl/o_writeback_unit_pkg.sv
// rtl/o_writeback_unit_pkg.sv - shared memory-bus types, vector type, beat count and writeback states
package o_writeback_unit_pkg;

   typedef logic [31:0]  ADDR;
   typedef logic [63:0]  MEM_BLOCK;
   typedef logic [3:0]   MEM_TAG;
   typedef logic [255:0] O_VECTOR_T;

   typedef enum logic [1:0] {
      MEM_NONE  = 2'd0,
      MEM_LOAD  = 2'd1,
      MEM_STORE = 2'd2
   } MEM_COMMAND;

   typedef enum logic [1:0] {
      IDLE,
      WAIT_VEC,
      ISSUE,
      DONE
   } wb_state_t;

   // One 64-bit store per beat of an output vector.
   localparam int BEATS  = $bits(O_VECTOR_T) / 64;
   localparam int BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

endpackage

// File: rtl/o_writeback_unit_if.sv
// rtl/o_writeback_unit_if.sv - vector drain handshake and memory store bus
interface o_writeback_unit_if;
   import o_writeback_unit_pkg::*;

   logic       o_vld;
   O_VECTOR_T  o_vector;
   logic       o_rdy;
   MEM_TAG     mem2proc_transaction_tag;
   MEM_COMMAND proc2mem_command;
   ADDR        proc2mem_addr;
   MEM_BLOCK   proc2mem_data;

   // Environment side: upstream drain stage plus memory.
   modport master (
      output o_vld, o_vector, mem2proc_transaction_tag,
      input  o_rdy, proc2mem_command, proc2mem_addr, proc2mem_data
   );

   // Writeback unit side.
   modport slave (
      input  o_vld, o_vector, mem2proc_transaction_tag,
      output o_rdy, proc2mem_command, proc2mem_addr, proc2mem_data
   );

endinterface

// File: rtl/o_writeback_unit_beat_mux.sv
// rtl/o_writeback_unit_beat_mux.sv - selects the 64-bit slice of a vector for a beat index
module wb_beat_mux
   import o_writeback_unit_pkg::*;
(
   input  O_VECTOR_T         vec,
   input  logic [BEAT_W-1:0] beat,
   output MEM_BLOCK          slice
);

   // Constant-indexed compare per beat keeps the select free of variable part-selects.
   always_comb begin
      slice = '0;
      for (int i = 0; i < BEATS; i++) begin
         if (beat == BEAT_W'(i)) slice = vec[i*64 +: 64];
      end
   end

endmodule

// File: rtl/o_writeback_unit.sv
// rtl/o_writeback_unit.sv - drains output vectors into 64-bit memory stores; optional skid buffer under AURA_WB_SKID_EN
module o_writeback_unit
   import o_writeback_unit_pkg::*;
#(
   parameter ADDR O_BASE_ADDR = 32'h0000_1000,
   parameter int  NUM_O_ROWS  = 64
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   output logic              wb_done,
   o_writeback_unit_if.slave wb
);

   localparam int                ROW_W     = $clog2(NUM_O_ROWS + 1);
   localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);
   localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_O_ROWS - 1);

   if (BEATS < 1 || ($bits(O_VECTOR_T) % 64) != 0) begin : g_beats_check
      $error("O_VECTOR_T must be a nonzero multiple of 64 bits");
   end

   wb_state_t         state;
   logic [ROW_W-1:0]  row;
   logic [BEAT_W-1:0] beat;
   O_VECTOR_T         vec_buf;
   MEM_BLOCK          beat_slice;
   logic              rdy_q;
   MEM_COMMAND        cmd_q;
   ADDR               addr_q;
   logic              done_q;

`ifdef AURA_WB_SKID_EN
   O_VECTOR_T         skid_buf;
   logic              skid_full;
`endif

   logic beat_acc;
   logic last_beat;
   logic last_row;
   logic vec_take;

   assign beat_acc  = (state == ISSUE) && (wb.mem2proc_transaction_tag != '0);
   assign last_beat = (beat == LAST_BEAT);
   assign last_row  = (row == LAST_ROW);
   assign vec_take  = wb.o_vld && rdy_q;

   assign wb.o_rdy            = rdy_q;
   assign wb.proc2mem_command = cmd_q;
   assign wb.proc2mem_addr    = addr_q;
   assign wb.proc2mem_data    = (cmd_q == MEM_STORE) ? beat_slice : '0;
   assign wb_done             = done_q;

   // Byte address of beat 0 of a row; wraps modulo 2^32.
   function automatic ADDR row_addr(input logic [ROW_W-1:0] r);
      return O_BASE_ADDR + ADDR'(r) * ADDR'(BEATS * 8);
   endfunction

   wb_beat_mux u_beat_mux (
      .vec   (vec_buf),
      .beat  (beat),
      .slice (beat_slice)
   );

   // Run sequencing: vector capture, per-beat store with retry on zero tag, row advance, done.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= IDLE;
         row     <= '0;
         beat    <= '0;
         vec_buf <= '0;
         rdy_q   <= 1'b0;
         cmd_q   <= MEM_NONE;
         addr_q  <= '0;
         done_q  <= 1'b0;
`ifdef AURA_WB_SKID_EN
         skid_buf  <= '0;
         skid_full <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  row   <= '0;
                  beat  <= '0;
                  rdy_q <= 1'b1;
                  state <= WAIT_VEC;
               end
            end
            WAIT_VEC: begin
               if (vec_take) begin
                  vec_buf <= wb.o_vector;
                  beat    <= '0;
                  cmd_q   <= MEM_STORE;
                  addr_q  <= row_addr(row);
`ifdef AURA_WB_SKID_EN
                  rdy_q   <= !last_row;
`else
                  rdy_q   <= 1'b0;
`endif
                  state   <= ISSUE;
               end
            end
            ISSUE: begin
`ifdef AURA_WB_SKID_EN
               if (vec_take) begin
                  skid_buf  <= wb.o_vector;
                  skid_full <= 1'b1;
                  rdy_q     <= 1'b0;
               end
`endif
               if (beat_acc) begin
                  if (!last_beat) begin
                     beat   <= beat + 1'b1;
                     addr_q <= addr_q + 32'd8;
                  end else begin
                     row  <= row + 1'b1;
                     beat <= '0;
                     if (last_row) begin
                        state  <= DONE;
                        cmd_q  <= MEM_NONE;
                        addr_q <= '0;
                        rdy_q  <= 1'b0;
                        done_q <= 1'b1;
                     end
`ifdef AURA_WB_SKID_EN
                     else if (skid_full || vec_take) begin
                        // Next row already buffered: keep issuing without a WAIT_VEC bubble.
                        vec_buf   <= skid_full ? skid_buf : wb.o_vector;
                        skid_full <= 1'b0;
                        addr_q    <= row_addr(row + 1'b1);
                        rdy_q     <= ((row + 1'b1) != LAST_ROW);
                     end
`endif
                     else begin
                        state  <= WAIT_VEC;
                        cmd_q  <= MEM_NONE;
                        addr_q <= '0;
                        rdy_q  <= 1'b1;
                     end
                  end
               end
            end
            DONE: begin
               if (start) begin
                  row    <= '0;
                  beat   <= '0;
                  done_q <= 1'b0;
                  rdy_q  <= 1'b1;
                  state  <= WAIT_VEC;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_o_writeback_unit.sv
// tb/tb_o_writeback_unit.sv - scoreboard bench for o_writeback_unit (BEATS=4, two rows, base 0x1000)
module tb_o_writeback_unit;
   import o_writeback_unit_pkg::*;

   localparam int  NROWS = 2;
   localparam ADDR BASE  = 32'h0000_1000;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic start = 1'b0;
   logic wb_done;

   o_writeback_unit_if wb ();

   o_writeback_unit #(
      .O_BASE_ADDR (BASE),
      .NUM_O_ROWS  (NROWS)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .start   (start),
      .wb_done (wb_done),
      .wb      (wb)
   );

   always #5 clk = ~clk;

   int          n_checks = 0;
   int          n_pass   = 0;
   O_VECTOR_T   vec_q[$];
   logic [95:0] exp_q[$];
   int          exp_row    = 0;
   logic        prev_vld   = 1'b0;
   logic        prev_rdy   = 1'b0;
   logic        start_req  = 1'b0;
   logic        offer_en   = 1'b0;
   ADDR         stall_addr = '0;
   int          stall_left = 0;
   int          cyc        = 0;

   function automatic O_VECTOR_T rand_vec();
      O_VECTOR_T r;
      for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // One clock: sample outputs at the falling edge, resolve the last handshake, drive next inputs.
   task automatic clk_step(output logic seen, output logic acc, output ADDR a, output MEM_BLOCK d);
      O_VECTOR_T v;
      logic      stall;
      @(negedge clk);
      cyc++;
      seen = (wb.proc2mem_command == MEM_STORE);
      a    = wb.proc2mem_addr;
      d    = wb.proc2mem_data;
      if (prev_vld && prev_rdy && vec_q.size() > 0) begin
         v = vec_q.pop_front();
         for (int b = 0; b < BEATS; b++)
            exp_q.push_back({BASE + ADDR'((exp_row * BEATS + b) * 8), v[b*64 +: 64]});
         exp_row++;
      end
      stall = seen && (a == stall_addr) && (stall_left > 0);
      if (stall) stall_left--;
      wb.mem2proc_transaction_tag = stall ? MEM_TAG'(0) : MEM_TAG'(1);
      acc       = seen && !stall;
      start     = start_req;
      start_req = 1'b0;
      wb.o_vld    = offer_en && (vec_q.size() > 0);
      wb.o_vector = (vec_q.size() > 0) ? vec_q[0] : '0;
      prev_vld    = wb.o_vld;
      prev_rdy    = wb.o_rdy;
   endtask

   task automatic test_reset();
      logic seen, acc;
      ADDR a;
      MEM_BLOCK d;
      wb.o_vld = 1'b0;
      wb.o_vector = '0;
      wb.mem2proc_transaction_tag = '0;
      repeat (2) @(negedge clk);
      n_checks++; if (wb.o_rdy !== 1'b0) $display("FAIL reset_o_rdy: got %b, expected 0", wb.o_rdy); else n_pass++;
      n_checks++; if (wb.proc2mem_command !== MEM_NONE) $display("FAIL reset_cmd: got %0d, expected MEM_NONE", wb.proc2mem_command); else n_pass++;
      n_checks++; if (wb.proc2mem_addr !== 32'h0) $display("FAIL reset_addr: got %h, expected 0", wb.proc2mem_addr); else n_pass++;
      n_checks++; if (wb.proc2mem_data !== 64'h0) $display("FAIL reset_data: got %h, expected 0", wb.proc2mem_data); else n_pass++;
      n_checks++; if (wb_done !== 1'b0) $display("FAIL reset_wb_done: got %b, expected 0", wb_done); else n_pass++;
      rst = 1'b1;
      repeat (2) clk_step(seen, acc, a, d);
      n_checks++; if (wb.o_rdy !== 1'b0 || seen) $display("FAIL idle_hold: got o_rdy=%b store=%b, expected 0/0", wb.o_rdy, seen); else n_pass++;
   endtask

   task automatic test_basic_run();
      logic seen, acc;
      ADDR a;
      MEM_BLOCK d;
      int stores = 0;
      exp_row = 0;
      vec_q.push_back(rand_vec());
      vec_q.push_back(rand_vec());
      offer_en  = 1'b1;
      start_req = 1'b1;
      for (int i = 0; i < 200 && !wb_done; i++) begin
         clk_step(seen, acc, a, d);
         if (seen) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL basic_store: got addr=%h, expected no store", a);
            else if ({a, d} !== exp_q[0]) $display("FAIL basic_store: got %h/%h, expected %h/%h", a, d, exp_q[0][95:64], exp_q[0][63:0]);
            else n_pass++;
            if (acc && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) stores++;
         end
      end
      n_checks++; if (stores !== 8) $display("FAIL basic_store_count: got %0d, expected 8", stores); else n_pass++;
      n_checks++; if (wb_done !== 1'b1) $display("FAIL basic_wb_done: got %b, expected 1", wb_done); else n_pass++;
      n_checks++; if (exp_q.size() !== 0) $display("FAIL basic_leftover: got %0d pending, expected 0", exp_q.size()); else n_pass++;
      clk_step(seen, acc, a, d);
      n_checks++;
      if (wb_done !== 1'b1 || wb.o_rdy !== 1'b0 || seen)
         $display("FAIL done_hold: got wb_done=%b o_rdy=%b store=%b, expected 1/0/0", wb_done, wb.o_rdy, seen);
      else n_pass++;
   endtask

   task automatic test_retry();
      logic seen, acc;
      ADDR a;
      MEM_BLOCK d;
      int stores = 0;
      int held = 0;
      exp_row = 0;
      vec_q.push_back(rand_vec());
      vec_q.push_back(rand_vec());
      stall_addr = 32'h0000_1010;
      stall_left = 3;
      start_req  = 1'b1;
      clk_step(seen, acc, a, d);
      clk_step(seen, acc, a, d);
      n_checks++;
      if (wb_done !== 1'b0 || wb.o_rdy !== 1'b1)
         $display("FAIL restart_from_done: got wb_done=%b o_rdy=%b, expected 0/1", wb_done, wb.o_rdy);
      else n_pass++;
      for (int i = 0; i < 200 && !wb_done; i++) begin
         clk_step(seen, acc, a, d);
         if (seen) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL retry_store: got addr=%h, expected no store", a);
            else if ({a, d} !== exp_q[0]) $display("FAIL retry_store: got %h/%h, expected %h/%h", a, d, exp_q[0][95:64], exp_q[0][63:0]);
            else n_pass++;
            if (acc && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) stores++;
            if (a == 32'h0000_1010) held++;
         end
      end
      n_checks++; if (held !== 4) $display("FAIL retry_hold_cycles: got %0d, expected 4", held); else n_pass++;
      n_checks++; if (stores !== 8) $display("FAIL retry_store_count: got %0d, expected 8", stores); else n_pass++;
      n_checks++; if (wb_done !== 1'b1) $display("FAIL retry_wb_done: got %b, expected 1", wb_done); else n_pass++;
   endtask

   task automatic test_vld_during_issue();
      logic seen, acc;
      ADDR a;
      MEM_BLOCK d;
      int stores = 0;
      int rdy_cnt = 0;
      int acc_cyc = -1;
      int row1_cyc = -1;
      logic pulsed = 1'b0;
      int exp_gap;
      int exp_rdy;
`ifdef AURA_WB_SKID_EN
      exp_gap = 1;
      exp_rdy = 1;
`else
      exp_gap = 2;
      exp_rdy = 0;
`endif
      exp_row = 0;
      vec_q.push_back(rand_vec());
      vec_q.push_back(rand_vec());
      start_req = 1'b1;
      for (int i = 0; i < 200 && (i < 3 || !wb_done); i++) begin
         clk_step(seen, acc, a, d);
         if (seen) begin
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL issue_store: got addr=%h, expected no store", a);
            else if ({a, d} !== exp_q[0]) $display("FAIL issue_store: got %h/%h, expected %h/%h", a, d, exp_q[0][95:64], exp_q[0][63:0]);
            else n_pass++;
            if (acc && exp_q.size() > 0) void'(exp_q.pop_front());
            if (acc) stores++;
            if (wb.o_rdy) rdy_cnt++;
            if (acc && a == 32'h0000_1018) acc_cyc = cyc;
            if (a == 32'h0000_1020 && row1_cyc < 0) row1_cyc = cyc;
            if (a == 32'h0000_1008 && !pulsed) begin
               start_req = 1'b1;
               pulsed = 1'b1;
            end
         end
      end
      n_checks++; if (rdy_cnt !== exp_rdy) $display("FAIL issue_o_rdy_cycles: got %0d, expected %0d", rdy_cnt, exp_rdy); else n_pass++;
      n_checks++; if (row1_cyc - acc_cyc !== exp_gap) $display("FAIL row1_gap: got %0d, expected %0d", row1_cyc - acc_cyc, exp_gap); else n_pass++;
      n_checks++; if (stores !== 8) $display("FAIL issue_store_count: got %0d, expected 8", stores); else n_pass++;
      n_checks++; if (wb_done !== 1'b1) $display("FAIL issue_wb_done: got %b, expected 1", wb_done); else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic seen, acc;
      ADDR a;
      MEM_BLOCK d;
      logic hit = 1'b0;
      exp_row = 0;
      vec_q.push_back(rand_vec());
      start_req = 1'b1;
      for (int i = 0; i < 20 && !hit; i++) begin
         clk_step(seen, acc, a, d);
         if (seen && a == 32'h0000_1008) hit = 1'b1;
      end
      n_checks++; if (!hit) $display("FAIL midrun_reach_beat1: got timeout, expected store at 00001008"); else n_pass++;
      rst = 1'b0;
      #1;
      n_checks++;
      if (wb.proc2mem_command !== MEM_NONE || wb.proc2mem_addr !== 32'h0 || wb.proc2mem_data !== 64'h0)
         $display("FAIL midrun_reset_bus: got cmd=%0d addr=%h data=%h, expected MEM_NONE/0/0",
                  wb.proc2mem_command, wb.proc2mem_addr, wb.proc2mem_data);
      else n_pass++;
      n_checks++; if (wb.o_rdy !== 1'b0 || wb_done !== 1'b0) $display("FAIL midrun_reset_ctl: got o_rdy=%b wb_done=%b, expected 0/0", wb.o_rdy, wb_done); else n_pass++;
      vec_q.delete();
      exp_q.delete();
      wb.o_vld = 1'b0;
      prev_vld = 1'b0;
      prev_rdy = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      repeat (3) clk_step(seen, acc, a, d);
      n_checks++;
      if (wb.o_rdy !== 1'b0 || wb_done !== 1'b0 || seen)
         $display("FAIL post_reset_idle: got o_rdy=%b wb_done=%b store=%b, expected 0/0/0", wb.o_rdy, wb_done, seen);
      else n_pass++;
      exp_row = 0;
      vec_q.push_back(rand_vec());
      start_req = 1'b1;
      hit = 1'b0;
      for (int i = 0; i < 10 && !hit; i++) begin
         clk_step(seen, acc, a, d);
         if (seen) begin
            hit = 1'b1;
            n_checks++;
            if (exp_q.size() == 0) $display("FAIL post_reset_store: got addr=%h, expected no store", a);
            else if ({a, d} !== exp_q[0]) $display("FAIL post_reset_store: got %h/%h, expected %h/%h", a, d, exp_q[0][95:64], exp_q[0][63:0]);
            else n_pass++;
         end
      end
      n_checks++; if (!hit) $display("FAIL post_reset_run: got timeout, expected store at 00001000"); else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic_run();
      test_retry();
      test_vld_during_issue();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
